// File: rtl/vm_pkg.sv
// rtl/vm_pkg.sv - shared encodings for the voicemail manager
//
// Holds the command opcodes, error codes and FSM state encodings used by
// voicemail_manager and its testable sub-blocks.
package vm_pkg;

    typedef enum logic [2:0] {
        VM_NOP         = 3'd0,
        VM_RECORD_NEXT = 3'd1,
        VM_PLAY        = 3'd2,
        VM_DELETE      = 3'd3,
        VM_DELETE_ALL  = 3'd4,
        VM_STOP        = 3'd5
    } vm_op_e;

    typedef enum logic [2:0] {
        VM_ERR_NONE       = 3'd0,
        VM_ERR_NO_CARD    = 3'd1,
        VM_ERR_FULL       = 3'd2,
        VM_ERR_EMPTY_SLOT = 3'd3,
        VM_ERR_OVERRUN    = 3'd4,
        VM_ERR_DISABLED   = 3'd5
    } vm_err_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_REC      = 3'd1,
        ST_REC_WR   = 3'd2,
        ST_PLAY_RD  = 3'd3,
        ST_PLAY_OUT = 3'd4,
        ST_CLEAR    = 3'd5
    } vm_state_e;

endpackage

// File: rtl/vm_slot_alloc.sv
// rtl/vm_slot_alloc.sv - lowest-free-slot encoder and used-slot popcount
//
// Ports:
//   used      in  per-slot occupancy bitmap
//   free_slot out lowest index with used==0 (0 when all used)
//   all_used  out every slot occupied
//   count     out number of occupied slots
module vm_slot_alloc #(
    parameter int NUM_SLOTS = 8,
    parameter int SLOT_W    = 3
) (
    input  logic [NUM_SLOTS-1:0] used,
    output logic [SLOT_W-1:0]    free_slot,
    output logic                 all_used,
    output logic [SLOT_W:0]      count
);

    always_comb begin
        free_slot = '0;
        all_used  = 1'b1;
        count     = '0;
        // Walk downwards so the last hit (lowest index) wins.
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!used[i]) begin
                free_slot = SLOT_W'(i);
                all_used  = 1'b0;
            end
            count = count + (SLOT_W + 1)'(used[i]);
        end
    end

endmodule

// File: rtl/voicemail_manager.sv
// rtl/voicemail_manager.sv - multi-slot voicemail record/playback controller
//
// Sits between the UI FSM and the CF-card word memory port.
// Ports:
//   clk, reset_n                  clock, async active-low reset
//   enable, cf_present            feature enable, card detect
//   cmd_valid/cmd_ready/cmd_op/cmd_slot   command handshake (ready in IDLE only)
//   smp_in_valid/smp_in           record samples (no backpressure)
//   smp_out_valid/smp_out_ready/smp_out   playback samples
//   mem_req/mem_we/mem_addr/mem_wdata/mem_ack/mem_rdata  word memory port
//   busy, active_slot, slot_used, slot_new, msg_count     status
//   err_valid/err_code            one-cycle error pulse
module voicemail_manager
    import vm_pkg::*;
#(
    parameter int NUM_SLOTS = 8,
    parameter int SLOT_W    = 3,
    parameter int LEN_W     = 12,
    parameter int DATA_W    = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic                    cf_present,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [2:0]              cmd_op,
    input  logic [SLOT_W-1:0]       cmd_slot,
    input  logic                    smp_in_valid,
    input  logic [DATA_W-1:0]       smp_in,
    output logic                    smp_out_valid,
    input  logic                    smp_out_ready,
    output logic [DATA_W-1:0]       smp_out,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [SLOT_W+LEN_W-1:0] mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    input  logic                    mem_ack,
    input  logic [DATA_W-1:0]       mem_rdata,
    output logic                    busy,
    output logic [SLOT_W-1:0]       active_slot,
    output logic [NUM_SLOTS-1:0]    slot_used,
    output logic [NUM_SLOTS-1:0]    slot_new,
    output logic [SLOT_W:0]         msg_count,
    output logic                    err_valid,
    output logic [2:0]              err_code
);

    localparam logic [LEN_W:0] SLOT_WORDS = {1'b1, {LEN_W{1'b0}}};

    vm_state_e             state_q, state_d;
    logic [SLOT_W-1:0]     slot_q, slot_d;
    logic [LEN_W:0]        idx_q, idx_d;
    logic [SLOT_W-1:0]     clr_q, clr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [DATA_W-1:0]     smp_out_q, smp_out_d;
    logic                  smp_out_valid_q, smp_out_valid_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic                  stop_q, stop_d;
    logic [NUM_SLOTS-1:0]  used_q, used_d;
    logic [NUM_SLOTS-1:0]  new_q, new_d;
    logic [LEN_W:0]        len_q [NUM_SLOTS];
    logic [LEN_W:0]        len_d [NUM_SLOTS];
    logic [SLOT_W:0]       msg_count_q, msg_count_d;
    logic                  err_valid_q, err_valid_d;
    logic [2:0]            err_code_q, err_code_d;
    logic                  cmd_ready_q, cmd_ready_d;

    logic [SLOT_W-1:0]     free_slot;
    logic                  all_used;
    logic [SLOT_W:0]       used_count;

    logic                  accept;
    logic                  stop_req;
    logic [LEN_W:0]        idx_inc;
    logic                  commit_en;
    logic [LEN_W:0]        commit_len;

    vm_slot_alloc #(
        .NUM_SLOTS (NUM_SLOTS),
        .SLOT_W    (SLOT_W)
    ) u_slot_alloc (
        .used      (used_q),
        .free_slot (free_slot),
        .all_used  (all_used),
        .count     (used_count)
    );

    assign accept   = cmd_valid && cmd_ready_q;
    // STOP bypasses cmd_ready; losing enable is treated the same way.
    assign stop_req = (cmd_valid && (cmd_op == VM_STOP)) || !enable;
    assign idx_inc  = idx_q + (LEN_W + 1)'(1);

    always_comb begin
        state_d         = state_q;
        slot_d          = slot_q;
        idx_d           = idx_q;
        clr_d           = clr_q;
        wdata_d         = wdata_q;
        smp_out_d       = smp_out_q;
        smp_out_valid_d = smp_out_valid_q;
        mem_req_d       = mem_req_q;
        mem_we_d        = mem_we_q;
        stop_d          = stop_q;
        used_d          = used_q;
        new_d           = new_q;
        len_d           = len_q;
        msg_count_d     = used_count;
        err_valid_d     = 1'b0;
        err_code_d      = VM_ERR_NONE;
        commit_en       = 1'b0;
        commit_len      = idx_q;

        case (state_q)
            ST_IDLE: begin
                if (accept && (cmd_op inside {VM_RECORD_NEXT, VM_PLAY, VM_DELETE, VM_DELETE_ALL})) begin
                    if (!enable) begin
                        err_valid_d = 1'b1;
                        err_code_d  = VM_ERR_DISABLED;
                    end else if (!cf_present) begin
                        err_valid_d = 1'b1;
                        err_code_d  = VM_ERR_NO_CARD;
                    end else if (cmd_op == VM_RECORD_NEXT) begin
                        if (all_used) begin
                            err_valid_d = 1'b1;
                            err_code_d  = VM_ERR_FULL;
                        end else begin
                            slot_d  = free_slot;
                            idx_d   = '0;
                            stop_d  = 1'b0;
                            state_d = ST_REC;
                        end
                    end else if (cmd_op == VM_DELETE_ALL) begin
                        clr_d   = '0;
                        state_d = ST_CLEAR;
                    end else if (!used_q[cmd_slot]) begin
                        err_valid_d = 1'b1;
                        err_code_d  = VM_ERR_EMPTY_SLOT;
                    end else if (cmd_op == VM_PLAY) begin
                        slot_d    = cmd_slot;
                        idx_d     = '0;
                        stop_d    = 1'b0;
                        mem_req_d = 1'b1;
                        mem_we_d  = 1'b0;
                        state_d   = ST_PLAY_RD;
                    end else begin
                        used_d[cmd_slot] = 1'b0;
                        new_d[cmd_slot]  = 1'b0;
                        len_d[cmd_slot]  = '0;
                    end
                end
            end

            ST_REC: begin
                if (!cf_present) begin
                    commit_en   = 1'b1;
                    state_d     = ST_IDLE;
                    err_valid_d = 1'b1;
                    err_code_d  = VM_ERR_NO_CARD;
                end else if (stop_req) begin
                    commit_en = 1'b1;
                    state_d   = ST_IDLE;
                end else if (smp_in_valid) begin
                    wdata_d   = smp_in;
                    mem_req_d = 1'b1;
                    mem_we_d  = 1'b1;
                    state_d   = ST_REC_WR;
                end
            end

            ST_REC_WR: begin
                if (!cf_present) begin
                    // Abandon the write; only previously acked words count.
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    commit_en   = 1'b1;
                    state_d     = ST_IDLE;
                    err_valid_d = 1'b1;
                    err_code_d  = VM_ERR_NO_CARD;
                end else begin
                    if (smp_in_valid) begin
                        err_valid_d = 1'b1;
                        err_code_d  = VM_ERR_OVERRUN;
                    end
                    if (mem_ack) begin
                        mem_req_d = 1'b0;
                        mem_we_d  = 1'b0;
                        idx_d     = idx_inc;
                        if (idx_inc == SLOT_WORDS || stop_q || stop_req) begin
                            commit_en  = 1'b1;
                            commit_len = idx_inc;
                            state_d    = ST_IDLE;
                        end else begin
                            state_d = ST_REC;
                        end
                    end else if (stop_req) begin
                        stop_d = 1'b1;
                    end
                end
            end

            ST_PLAY_RD: begin
                if (!cf_present) begin
                    mem_req_d   = 1'b0;
                    state_d     = ST_IDLE;
                    err_valid_d = 1'b1;
                    err_code_d  = VM_ERR_NO_CARD;
                end else if (mem_ack) begin
                    mem_req_d = 1'b0;
                    if (stop_q || stop_req) begin
                        state_d = ST_IDLE;
                    end else begin
                        smp_out_d       = mem_rdata;
                        smp_out_valid_d = 1'b1;
                        state_d         = ST_PLAY_OUT;
                    end
                end else if (stop_req) begin
                    stop_d = 1'b1;
                end
            end

            ST_PLAY_OUT: begin
                if (!cf_present) begin
                    smp_out_valid_d = 1'b0;
                    state_d         = ST_IDLE;
                    err_valid_d     = 1'b1;
                    err_code_d      = VM_ERR_NO_CARD;
                end else if (stop_req) begin
                    smp_out_valid_d = 1'b0;
                    state_d         = ST_IDLE;
                end else if (smp_out_ready) begin
                    smp_out_valid_d = 1'b0;
                    idx_d           = idx_inc;
                    if (idx_inc == len_q[slot_q]) begin
                        new_d[slot_q] = 1'b0;
                        state_d       = ST_IDLE;
                    end else begin
                        mem_req_d = 1'b1;
                        mem_we_d  = 1'b0;
                        state_d   = ST_PLAY_RD;
                    end
                end
            end

            ST_CLEAR: begin
                if (!cf_present) begin
                    state_d     = ST_IDLE;
                    err_valid_d = 1'b1;
                    err_code_d  = VM_ERR_NO_CARD;
                end else begin
                    used_d[clr_q] = 1'b0;
                    new_d[clr_q]  = 1'b0;
                    len_d[clr_q]  = '0;
                    clr_d         = clr_q + SLOT_W'(1);
                    if (clr_q == SLOT_W'(NUM_SLOTS - 1)) begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase

        // Zero-length recordings leave the slot free.
        if (commit_en && commit_len != '0) begin
            used_d[slot_q] = 1'b1;
            new_d[slot_q]  = 1'b1;
            len_d[slot_q]  = commit_len;
        end

        cmd_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            slot_q          <= '0;
            idx_q           <= '0;
            clr_q           <= '0;
            wdata_q         <= '0;
            smp_out_q       <= '0;
            smp_out_valid_q <= 1'b0;
            mem_req_q       <= 1'b0;
            mem_we_q        <= 1'b0;
            stop_q          <= 1'b0;
            used_q          <= '0;
            new_q           <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                len_q[i] <= '0;
            end
            msg_count_q     <= '0;
            err_valid_q     <= 1'b0;
            err_code_q      <= '0;
            cmd_ready_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            slot_q          <= slot_d;
            idx_q           <= idx_d;
            clr_q           <= clr_d;
            wdata_q         <= wdata_d;
            smp_out_q       <= smp_out_d;
            smp_out_valid_q <= smp_out_valid_d;
            mem_req_q       <= mem_req_d;
            mem_we_q        <= mem_we_d;
            stop_q          <= stop_d;
            used_q          <= used_d;
            new_q           <= new_d;
            len_q           <= len_d;
            msg_count_q     <= msg_count_d;
            err_valid_q     <= err_valid_d;
            err_code_q      <= err_code_d;
            cmd_ready_q     <= cmd_ready_d;
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign smp_out_valid = smp_out_valid_q;
    assign smp_out       = smp_out_q;
    assign mem_req       = mem_req_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = {slot_q, idx_q[LEN_W-1:0]};
    assign mem_wdata     = wdata_q;
    assign busy          = (state_q != ST_IDLE);
    assign active_slot   = slot_q;
    assign slot_used     = used_q;
    assign slot_new      = new_q;
    assign msg_count     = msg_count_q;
    assign err_valid     = err_valid_q;
    assign err_code      = err_code_q;

endmodule

// File: tb/tb_voicemail_manager.sv
// tb/tb_voicemail_manager.sv - directed self-checking bench for voicemail_manager
module tb_voicemail_manager;

    localparam logic [2:0] OP_REC = 3'd1, OP_PLAY = 3'd2, OP_DEL = 3'd3, OP_DELALL = 3'd4, OP_STOP = 3'd5;
    localparam logic [2:0] E_NOCARD = 3'd1, E_FULL = 3'd2, E_OVR = 3'd4, E_DIS = 3'd5;

    logic        clk = 1'b0;
    logic        reset_n, enable, cf_present, cmd_valid, cmd_ready;
    logic [2:0]  cmd_op, cmd_slot;
    logic        smp_in_valid, smp_out_valid, smp_out_ready;
    logic [15:0] smp_in, smp_out;
    logic        mem_req, mem_we, mem_ack;
    logic [6:0]  mem_addr;
    logic [15:0] mem_wdata, mem_rdata;
    logic        busy, err_valid;
    logic [2:0]  active_slot, err_code;
    logic [7:0]  slot_used, slot_new;
    logic [3:0]  msg_count;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [128];
    int ack_dly = 1;
    int ack_cnt = 0;
    int wr_count = 0;
    int ovr_cnt = 0;

    voicemail_manager #(.NUM_SLOTS(8), .SLOT_W(3), .LEN_W(4), .DATA_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .cf_present(cf_present),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_slot(cmd_slot),
        .smp_in_valid(smp_in_valid), .smp_in(smp_in),
        .smp_out_valid(smp_out_valid), .smp_out_ready(smp_out_ready), .smp_out(smp_out),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .busy(busy), .active_slot(active_slot), .slot_used(slot_used), .slot_new(slot_new),
        .msg_count(msg_count), .err_valid(err_valid), .err_code(err_code)
    );

    always #5 clk = ~clk;

    // Word memory: acks ack_dly falling edges after a request is seen.
    always @(negedge clk) begin
        if (mem_ack) begin
            mem_ack = 1'b0;
            ack_cnt = 0;
        end else if (mem_req) begin
            ack_cnt++;
            if (ack_cnt >= ack_dly) begin
                mem_ack = 1'b1;
                if (mem_we) begin
                    mem[mem_addr] = mem_wdata;
                    wr_count++;
                end else begin
                    mem_rdata = mem[mem_addr];
                end
            end
        end else begin
            ack_cnt = 0;
        end
    end

    always @(negedge clk) begin
        if (reset_n && err_valid && err_code == E_OVR) ovr_cnt++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [2:0] op, input logic [2:0] slot);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_slot  = slot;
        tick;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
    endtask

    task automatic record_msg(input int n, input logic [15:0] base, output logic [2:0] slot_seen);
        send_cmd(OP_REC, 3'd0);
        slot_seen = active_slot;
        for (int k = 0; k < n; k++) begin
            smp_in       = base + 16'(k);
            smp_in_valid = 1'b1;
            tick;
            smp_in_valid = 1'b0;
            repeat (3) tick;
        end
        send_cmd(OP_STOP, 3'd0);
    endtask

    task automatic test_reset;
        #12;
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready got %0h exp 0", cmd_ready); end
        checks++; if (busy !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL reset_busy_req got %0h %0h exp 0 0", busy, mem_req); end
        checks++; if (slot_used !== 8'h00 || msg_count !== 4'd0) begin errors++; $display("FAIL reset_used got %0h %0h exp 0 0", slot_used, msg_count); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        tick;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %0h exp 1", cmd_ready); end
    endtask

    task automatic test_record;
        int w0;
        logic [15:0] e;
        w0 = wr_count;
        send_cmd(OP_REC, 3'd0);
        checks++; if (busy !== 1'b1 || active_slot !== 3'd0) begin errors++; $display("FAIL rec_start got busy %0h slot %0h exp 1 0", busy, active_slot); end
        for (int k = 0; k < 5; k++) begin
            smp_in       = 16'((k + 1) * 16'h1111);
            smp_in_valid = 1'b1;
            tick;
            smp_in_valid = 1'b0;
            repeat (3) tick;
        end
        send_cmd(OP_STOP, 3'd0);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rec_stop_busy got %0h exp 0", busy); end
        checks++; if (slot_used !== 8'h01 || slot_new !== 8'h01) begin errors++; $display("FAIL rec_used_new got %0h %0h exp 01 01", slot_used, slot_new); end
        tick;
        checks++; if (msg_count !== 4'd1) begin errors++; $display("FAIL rec_msg_count got %0d exp 1", msg_count); end
        checks++; if (wr_count - w0 !== 5) begin errors++; $display("FAIL rec_writes got %0d exp 5", wr_count - w0); end
        for (int k = 0; k < 5; k++) begin
            e = 16'((k + 1) * 16'h1111);
            checks++; if (mem[k] !== e) begin errors++; $display("FAIL rec_word%0d got %h exp %h", k, mem[k], e); end
        end
    endtask

    task automatic test_play;
        logic [15:0] cap [5];
        logic [15:0] pv, e;
        logic pend;
        int got;
        got = 0;
        pend = 1'b0;
        pv = '0;
        send_cmd(OP_PLAY, 3'd0);
        for (int c = 0; c < 200 && got < 5; c++) begin
            if (pend) begin
                checks++; if (smp_out_valid !== 1'b1 || smp_out !== pv) begin errors++; $display("FAIL play_hold got %0h/%h exp 1/%h", smp_out_valid, smp_out, pv); end
            end
            smp_out_ready = (c % 2 == 0);
            pend = smp_out_valid && !smp_out_ready;
            pv   = smp_out;
            if (smp_out_valid && smp_out_ready) begin
                cap[got] = smp_out;
                got++;
            end
            tick;
        end
        smp_out_ready = 1'b0;
        checks++; if (got !== 5) begin errors++; $display("FAIL play_count got %0d exp 5", got); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL play_busy_end got %0h exp 0", busy); end
        checks++; if (slot_new !== 8'h00 || slot_used !== 8'h01) begin errors++; $display("FAIL play_new got %0h used %0h exp 00 01", slot_new, slot_used); end
        for (int k = 0; k < got; k++) begin
            e = 16'((k + 1) * 16'h1111);
            checks++; if (cap[k] !== e) begin errors++; $display("FAIL play_smp%0d got %h exp %h", k, cap[k], e); end
        end
    endtask

    task automatic test_full;
        logic [2:0] s;
        for (int i = 1; i < 8; i++) record_msg(2, 16'(i * 256), s);
        tick;
        checks++; if (slot_used !== 8'hFF || msg_count !== 4'd8) begin errors++; $display("FAIL full_used got %0h cnt %0d exp ff 8", slot_used, msg_count); end
        send_cmd(OP_REC, 3'd0);
        checks++; if (err_valid !== 1'b1 || err_code !== E_FULL || busy !== 1'b0) begin errors++; $display("FAIL full_err got %0h/%0d busy %0h exp 1/2 0", err_valid, err_code, busy); end
        send_cmd(OP_DEL, 3'd3);
        checks++; if (slot_used !== 8'hF7) begin errors++; $display("FAIL del3_used got %0h exp f7", slot_used); end
        tick;
        checks++; if (msg_count !== 4'd7) begin errors++; $display("FAIL del3_count got %0d exp 7", msg_count); end
        record_msg(2, 16'hC300, s);
        checks++; if (s !== 3'd3) begin errors++; $display("FAIL refill_slot got %0d exp 3", s); end
        tick;
        checks++; if (slot_used !== 8'hFF || msg_count !== 4'd8) begin errors++; $display("FAIL refill_used got %0h cnt %0d exp ff 8", slot_used, msg_count); end
        checks++; if (mem[49] !== 16'hC301) begin errors++; $display("FAIL refill_word got %h exp c301", mem[49]); end
    endtask

    task automatic test_overrun;
        int w0, o0, got;
        logic [15:0] last, e;
        send_cmd(OP_DEL, 3'd5);
        ack_dly = 3;
        send_cmd(OP_REC, 3'd0);
        checks++; if (active_slot !== 3'd5) begin errors++; $display("FAIL ovr_slot got %0d exp 5", active_slot); end
        w0 = wr_count;
        o0 = ovr_cnt;
        smp_in_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            smp_in = 16'(i);
            tick;
        end
        smp_in_valid = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL autostop_busy got %0h exp 0", busy); end
        tick;
        checks++; if (wr_count - w0 !== 16) begin errors++; $display("FAIL ovr_writes got %0d exp 16", wr_count - w0); end
        checks++; if (ovr_cnt - o0 !== 48) begin errors++; $display("FAIL ovr_pulses got %0d exp 48", ovr_cnt - o0); end
        for (int k = 0; k < 16; k++) begin
            e = 16'(4 * k);
            checks++; if (mem[80 + k] !== e) begin errors++; $display("FAIL ovr_word%0d got %h exp %h", k, mem[80 + k], e); end
        end
        send_cmd(OP_PLAY, 3'd5);
        smp_out_ready = 1'b1;
        got = 0;
        last = '0;
        for (int c = 0; c < 400 && busy; c++) begin
            if (smp_out_valid) begin
                got++;
                last = smp_out;
            end
            tick;
        end
        smp_out_ready = 1'b0;
        checks++; if (got !== 16 || last !== 16'd60) begin errors++; $display("FAIL ovr_play_len got %0d last %h exp 16 003c", got, last); end
        checks++; if (slot_new[5] !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL ovr_play_end got new %0h busy %0h exp 0 0", slot_new[5], busy); end
        ack_dly = 1;
    endtask

    task automatic test_cf_drop;
        ack_dly = 1000;
        send_cmd(OP_PLAY, 3'd0);
        tick;
        tick;
        checks++; if (mem_req !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL cf_pending got req %0h busy %0h exp 1 1", mem_req, busy); end
        cf_present = 1'b0;
        tick;
        checks++; if (busy !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL cf_abort got busy %0h req %0h exp 0 0", busy, mem_req); end
        checks++; if (err_valid !== 1'b1 || err_code !== E_NOCARD) begin errors++; $display("FAIL cf_err got %0h/%0d exp 1/1", err_valid, err_code); end
        send_cmd(OP_DEL, 3'd1);
        checks++; if (err_valid !== 1'b1 || err_code !== E_NOCARD || slot_used !== 8'hFF) begin errors++; $display("FAIL cf_reject got %0h/%0d used %0h exp 1/1 ff", err_valid, err_code, slot_used); end
        cf_present = 1'b1;
        ack_dly = 1;
        tick;
    endtask

    task automatic test_disabled;
        enable = 1'b0;
        send_cmd(OP_PLAY, 3'd0);
        checks++; if (err_valid !== 1'b1 || err_code !== E_DIS || busy !== 1'b0) begin errors++; $display("FAIL disabled got %0h/%0d busy %0h exp 1/5 0", err_valid, err_code, busy); end
        enable = 1'b1;
        tick;
    endtask

    task automatic test_delete_all;
        int n;
        for (int s = 3; s < 8; s++) send_cmd(OP_DEL, 3'(s));
        tick;
        checks++; if (slot_used !== 8'h07 || msg_count !== 4'd3) begin errors++; $display("FAIL pre_clear got %0h cnt %0d exp 07 3", slot_used, msg_count); end
        send_cmd(OP_DELALL, 3'd0);
        n = 0;
        while (busy && n < 50) begin
            n++;
            tick;
        end
        checks++; if (n !== 8) begin errors++; $display("FAIL clear_cycles got %0d exp 8", n); end
        checks++; if (slot_used !== 8'h00) begin errors++; $display("FAIL clear_used got %0h exp 00", slot_used); end
        tick;
        checks++; if (msg_count !== 4'd0) begin errors++; $display("FAIL clear_count got %0d exp 0", msg_count); end
    endtask

    task automatic test_reset_mid;
        logic [2:0] s;
        record_msg(1, 16'h7777, s);
        ack_dly = 1000;
        send_cmd(OP_REC, 3'd0);
        smp_in       = 16'hABCD;
        smp_in_valid = 1'b1;
        tick;
        smp_in_valid = 1'b0;
        checks++; if (mem_req !== 1'b1 || active_slot !== 3'd1 || slot_used !== 8'h01) begin errors++; $display("FAIL mid_pre got req %0h slot %0d used %0h exp 1 1 01", mem_req, active_slot, slot_used); end
        #3;
        reset_n = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 7'd0 || mem_wdata !== 16'd0) begin errors++; $display("FAIL mid_mem got %0h %0h %0h %h exp 0 0 0 0", mem_req, mem_we, mem_addr, mem_wdata); end
        checks++; if (busy !== 1'b0 || active_slot !== 3'd0 || cmd_ready !== 1'b0) begin errors++; $display("FAIL mid_state got %0h %0h %0h exp 0 0 0", busy, active_slot, cmd_ready); end
        checks++; if (slot_used !== 8'h00 || slot_new !== 8'h00 || msg_count !== 4'd0) begin errors++; $display("FAIL mid_table got %0h %0h %0d exp 0 0 0", slot_used, slot_new, msg_count); end
        checks++; if (err_valid !== 1'b0 || smp_out_valid !== 1'b0) begin errors++; $display("FAIL mid_out got %0h %0h exp 0 0", err_valid, smp_out_valid); end
        ack_dly = 1;
        tick;
        reset_n = 1'b1;
        tick;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_release got %0h exp 1", cmd_ready); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0; enable = 1'b1; cf_present = 1'b1;
        cmd_valid = 1'b0; cmd_op = 3'd0; cmd_slot = 3'd0;
        smp_in_valid = 1'b0; smp_in = '0; smp_out_ready = 1'b0;
        mem_ack = 1'b0; mem_rdata = '0;
        test_reset;
        test_record;
        test_play;
        test_full;
        test_overrun;
        test_cf_drop;
        test_disabled;
        test_delete_all;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/voicemail_manager.md
Name: voicemail_manager

Overview:
- Multi-slot voicemail store/playback controller between the user-interface FSM and the CF-card word memory port.
- Generalises the single on/off voicemail toggle and status nibble into NUM_SLOTS message slots.
- Supports per-slot length and new-message tracking, record/play/delete commands, auto-stop on full slot, and abort on card removal.
- Audio side uses 16-bit samples matching audio_in_data/audio_out_data.

Parameters:
- NUM_SLOTS, 8, number of message slots (power of 2, >=2)
- SLOT_W, 3, log2(NUM_SLOTS)
- LEN_W, 12, log2 words per slot; slot capacity SLOT_WORDS = 2**LEN_W
- DATA_W, 16, sample width

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset; asynchronous assert, active-low
- enable  in  1  voicemail feature on (from UI menu)
- cf_present  in  1  CF card detected
- cmd_valid  in  1  command strobe
- cmd_ready  out  1  manager can accept command (IDLE only)
- cmd_op  in  3  0 NOP, 1 RECORD_NEXT, 2 PLAY, 3 DELETE, 4 DELETE_ALL, 5 STOP
- cmd_slot  in  SLOT_W  target slot for PLAY/DELETE
- smp_in_valid  in  1  incoming sample strobe while recording
- smp_in  in  DATA_W  incoming sample
- smp_out_valid  out  1  playback sample valid
- smp_out_ready  in  1  consumer accepts playback sample
- smp_out  out  DATA_W  playback sample
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1 write, 0 read
- mem_addr  out  SLOT_W+LEN_W  {slot, word index}
- mem_wdata  out  DATA_W  write data
- mem_ack  in  1  one-cycle completion; mem_rdata valid with it
- mem_rdata  in  DATA_W  read data
- busy  out  1  not IDLE
- active_slot  out  SLOT_W  slot being recorded/played
- slot_used  out  NUM_SLOTS  slot holds a message
- slot_new  out  NUM_SLOTS  message not yet played
- msg_count  out  SLOT_W+1  popcount(slot_used)
- err_valid  out  1  one-cycle error pulse
- err_code  out  3  0 none, 1 NO_CARD, 2 FULL, 3 EMPTY_SLOT, 4 OVERRUN, 5 DISABLED

Behaviour:
- Reset: all outputs 0, state IDLE, length table cleared, cmd_ready 0 during reset; first cycle after release cmd_ready=1.
- States: IDLE, REC, REC_WR, PLAY_RD, PLAY_OUT, CLEAR.
- IDLE: cmd_ready=1. A command is accepted on cmd_valid&cmd_ready; state changes on the next edge. STOP/NOP in IDLE are ignored.
- Command rejection (stays IDLE, err_valid pulses the cycle after accept):
  - enable=0 -> DISABLED (any op except NOP/STOP).
  - cf_present=0 -> NO_CARD.
  - RECORD_NEXT with all slots used -> FULL.
  - PLAY/DELETE of an unused slot -> EMPTY_SLOT.
- RECORD_NEXT: picks the lowest-index free slot, word index 0, enters REC.
  - REC: on smp_in_valid, latch sample, go to REC_WR with mem_req=1, mem_we=1, addr={slot,idx}.
  - On mem_ack: idx++, return to REC.
  - smp_in_valid during REC_WR: sample dropped, err OVERRUN pulses, recording continues.
  - idx reaching SLOT_WORDS: auto-stop. Length saturates at SLOT_WORDS; stored length needs LEN_W+1 bits.
- STOP: honoured during REC/PLAY even though cmd_ready=0 (stop path bypasses the handshake). In REC_WR, the stop takes effect after mem_ack.
- Record commit: if length>0, set slot_used and slot_new, store length. A length-0 recording leaves the slot free.
- PLAY: idx=0, enters PLAY_RD and issues a read.
  - On mem_ack: capture rdata into smp_out, go to PLAY_OUT with smp_out_valid=1. smp_out holds stable until smp_out_ready.
  - On handshake: idx++. If idx==length, go to IDLE and clear slot_new; else back to PLAY_RD.
  - A STOP before the end leaves slot_new set.
- DELETE: clears used/new/length of that slot in one cycle, then IDLE.
- DELETE_ALL: CLEAR state walks one slot per cycle, NUM_SLOTS cycles, then IDLE.
- cf_present falling in any non-IDLE state:
  - No new mem_req is issued; an outstanding request is dropped without waiting for ack.
  - Go to IDLE and pulse NO_CARD.
  - A recording in progress commits the words already acked.
- enable falling mid-operation behaves as STOP.
- msg_count is registered and updates the cycle after slot_used changes.
- Async reset mid-operation: everything clears immediately; no memory cleanup.

Decomposition:
- Package vm_pkg holds:
  - cmd_op encodings (VM_NOP..VM_STOP)
  - err_code encodings
  - state encodings
- One sub-module, vm_slot_alloc: combinational lowest-free-slot priority encoder plus popcount over slot_used, parameterised by NUM_SLOTS.

Test Plan:
- Reset; enable=1, cf_present=1, RECORD_NEXT; feed 5 samples 0x1111..0x5555 spaced 4 cycles with mem_ack 1 cycle after req; then STOP -> slot_used=0x01, slot_new=0x01, msg_count=1, mem_addr 0..4 in slot 0 with the matching wdata.
- PLAY slot 0 with smp_out_ready toggling 1-0 -> smp_out emits 0x1111..0x5555 in order, each held until accepted; slot_new=0x00 afterwards; busy falls the cycle after the 5th handshake.
- Record 8 messages, then RECORD_NEXT -> err FULL pulse. DELETE slot 3, then RECORD_NEXT -> records into slot 3, msg_count=8.
- Record with mem_ack delayed 3 cycles and smp_in_valid every cycle -> OVERRUN pulses on every dropped sample; stored length equals the number of acked writes. With LEN_W=4, 16 writes trigger auto-stop.
- Drop cf_present during PLAY_RD with ack pending -> IDLE next cycle, err NO_CARD, mem_req=0. Commands issued while cf_present=0 are rejected with NO_CARD.
- enable=0 then PLAY -> DISABLED pulse. DELETE_ALL with 3 slots used -> busy for exactly NUM_SLOTS cycles, then slot_used=0 and msg_count=0. Assert reset_n low mid-record -> all outputs 0 asynchronously.
